// File: rtl/eig_pkg.sv
// Shared types and constants for the QR eigenvalue datapath and its controller.
package eig_pkg;

  localparam int ELEM_W  = 16;
  localparam int MAT_DIM = 4;
  localparam int MAT_W   = ELEM_W * MAT_DIM * MAT_DIM;

  // Matrix elements are signed Q4.12 fixed point.
  localparam int FRAC_W = 12;
  localparam int INT_W  = ELEM_W - FRAC_W;
  localparam logic [ELEM_W-1:0] FX_ONE = ELEM_W'(1 << FRAC_W);

  typedef enum logic [2:0] {
    IDLE,
    QR_ISSUE,
    QR_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle watchdog: counts enabled cycles since the last clear, flags the LIMIT-th one.
// Compiled only when QR_WATCHDOG_EN is defined.
`ifdef QR_WATCHDOG_EN
module stage_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the cycle whose increment would make the count reach LIMIT.
  assign expired = enable && (cnt == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/qr_iter_ctrl.sv
// QR iteration sequencer: steps QR and R*Q stages on their done signals, polls diagonality, caps at MAX_ITER.
// Optional per-stage watchdog and timeout_err port are built when QR_WATCHDOG_EN is defined.
module qr_iter_ctrl
  import eig_pkg::*;
#(
  parameter int MAX_ITER = 64,
  parameter int ITER_W   = 7
`ifdef QR_WATCHDOG_EN
  ,
  parameter int WD_CYCLES = 1023
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAT_W-1:0]  a_init,
  input  logic              qr_done,
  input  logic              mult_done,
  input  logic [MAT_W-1:0]  a_new,
  input  logic              exit_flag,
  output logic [MAT_W-1:0]  a_cur,
  output logic              qr_start,
  output logic              mult_start,
  output logic [MAT_W-1:0]  a_diag,
  output logic              eig_enable,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_count,
  output logic              max_iter_hit
`ifdef QR_WATCHDOG_EN
  ,
  output logic              timeout_err
`endif
);

  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

  state_t state, state_nxt;
  logic   accept, capture, finish, cap_hit, wd_fire, wd_expired;

`ifdef QR_WATCHDOG_EN
  logic wd_clear, wd_enable;

  assign wd_clear  = (state == QR_ISSUE) || (state == MUL_ISSUE);
  assign wd_enable = (state == QR_WAIT) || (state == MUL_WAIT);

  stage_watchdog #(.LIMIT(WD_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    qr_start   = 1'b0;
    mult_start = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    cap_hit    = 1'b0;
    wd_fire    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = QR_ISSUE;
        end
      end
      QR_ISSUE: begin
        qr_start  = 1'b1;
        state_nxt = QR_WAIT;
      end
      QR_WAIT: begin
        if (qr_done) begin
          state_nxt = MUL_ISSUE;
        end else if (wd_expired) begin
          wd_fire   = 1'b1;
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      MUL_ISSUE: begin
        mult_start = 1'b1;
        state_nxt  = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mult_done) begin
          capture   = 1'b1;
          state_nxt = CHECK;
        end else if (wd_expired) begin
          wd_fire   = 1'b1;
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      CHECK: begin
        // Convergence is tested before the cap so a last-iteration hit reports as converged.
        if (exit_flag) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (iter_count == ITER_CAP) begin
          finish    = 1'b1;
          cap_hit   = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = QR_ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done       = (state == DONE);
  assign eig_enable = (state == DONE);
  assign busy       = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a_cur        <= '0;
      a_diag       <= '0;
      iter_count   <= '0;
      max_iter_hit <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_cur        <= a_init;
        iter_count   <= '0;
        max_iter_hit <= 1'b0;
      end else if (capture) begin
        a_cur <= a_new;
        if (iter_count != ITER_CAP) begin
          iter_count <= iter_count + 1'b1;
        end
      end
      if (finish) begin
        a_diag       <= a_cur;
        max_iter_hit <= cap_hit;
      end
    end
  end

`ifdef QR_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      timeout_err <= 1'b0;
    end else if (wd_fire) begin
      timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qr_iter_ctrl.sv
// Bench for qr_iter_ctrl: stub QR / R*Q stages with fixed latencies, table and random runs vs. a cycle-count model.
module tb_qr_iter_ctrl;

  localparam int MAX_IT = 4;
  localparam int IW     = 3;

  logic          clk = 1'b0;
  logic          rst, start, qr_done, mult_done, exit_flag;
  logic [255:0]  a_init, a_new, a_cur, a_diag;
  logic          qr_start, mult_start, eig_enable, busy, done, max_iter_hit;
  logic [IW-1:0] iter_count;
`ifdef QR_WATCHDOG_EN
  logic          timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  // Stub stage configuration and observation.
  int cfg_dq = 1, cfg_dm = 1, cfg_conv = 0;
  int run_id = 0, seen_id = 0;
  int n_qr = 0, n_mul = 0, qcnt = 0, mcnt = 0, it_s = 0;
  bit flag_pend = 0;
  logic [255:0] a_hist [16];

  typedef struct {
    int dq;
    int dm;
    int conv;
    int exp_iter;
    bit exp_hit;
    int exp_lat;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  qr_iter_ctrl #(
    .MAX_ITER (MAX_IT),
    .ITER_W   (IW)
`ifdef QR_WATCHDOG_EN
    ,
    .WD_CYCLES(16)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_init       (a_init),
    .qr_done      (qr_done),
    .mult_done    (mult_done),
    .a_new        (a_new),
    .exit_flag    (exit_flag),
    .a_cur        (a_cur),
    .qr_start     (qr_start),
    .mult_start   (mult_start),
    .a_diag       (a_diag),
    .eig_enable   (eig_enable),
    .busy         (busy),
    .done         (done),
    .iter_count   (iter_count),
    .max_iter_hit (max_iter_hit)
`ifdef QR_WATCHDOG_EN
    ,
    .timeout_err  (timeout_err)
`endif
  );

  // Stub stages: done arrives cfg_dq / cfg_dm cycles after the start pulse; exit_flag one cycle after mult_done.
  initial begin
    qr_done = 1'b0; mult_done = 1'b0; exit_flag = 1'b0; a_new = '0;
    forever begin
      @(negedge clk);
      if (run_id != seen_id) begin
        seen_id = run_id;
        qcnt = 0; mcnt = 0; it_s = 0; flag_pend = 0; n_qr = 0; n_mul = 0;
        qr_done = 1'b0; mult_done = 1'b0; exit_flag = 1'b0;
      end else begin
        qr_done   = 1'b0;
        mult_done = 1'b0;
        exit_flag = flag_pend;
        flag_pend = 0;
        if (qcnt > 0) begin
          qcnt--;
          if (qcnt == 0) qr_done = 1'b1;
        end
        if (qr_start) begin
          qcnt = cfg_dq;
          n_qr++;
        end
        if (mcnt > 0) begin
          mcnt--;
          if (mcnt == 0) begin
            mult_done = 1'b1;
            if (it_s < 15) it_s++;
            a_new     = a_hist[it_s];
            flag_pend = (it_s == cfg_conv);
          end
        end
        if (mult_start) begin
          mcnt = cfg_dm;
          n_mul++;
        end
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference: run length follows from the convergence iteration and the cap; each iteration
  // costs one issue cycle per stage, each stage's latency, and one check cycle.
  function automatic void model(input int dq, input int dm, input int conv,
                                output int it, output bit hit, output int lat);
    hit = !(conv >= 1 && conv <= MAX_IT);
    it  = hit ? MAX_IT : conv;
    lat = it * (dq + dm + 3) + 1;
  endfunction

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk_v({tag, "_a_cur"}, a_cur, '0);
    chk_v({tag, "_a_diag"}, a_diag, '0);
    chk_i({tag, "_iter"}, int'(iter_count), 0);
    chk_i({tag, "_flags"}, int'({done, busy, eig_enable, qr_start, mult_start, max_iter_hit}), 0);
`ifdef QR_WATCHDOG_EN
    chk_i({tag, "_timeout"}, int'(timeout_err), 0);
`endif
  endtask

  task automatic run_check(input int dq, input int dm, input int conv, input int exp_iter,
                           input bit exp_hit, input int exp_lat, input bit mid_start);
    logic [255:0] ai;
    int n;
    ai = rnd256();
    for (int i = 0; i < 16; i++) a_hist[i] = rnd256();
    cfg_dq = dq; cfg_dm = dm; cfg_conv = conv;
    run_id++;
    start = 1'b1; a_init = ai;
    @(posedge clk); #1;
    start = 1'b0; n = 1;
    chk_v("start_a_cur", a_cur, ai);
    chk_i("start_iter", int'(iter_count), 0);
    chk_i("start_done_drop", int'(done), 0);
    chk_i("start_qr_pulse", int'(qr_start), 1);
    chk_i("start_busy", int'(busy), 1);
    if (mid_start) begin
      @(posedge clk); #1; n++;
      start = 1'b1; a_init = ~ai;
      @(posedge clk); #1; n++;
      start = 1'b0;
    end
    while (!done && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    chk_i("done_reached", int'(done), 1);
    chk_i("latency", n, exp_lat);
    chk_i("iter_count", int'(iter_count), exp_iter);
    chk_i("max_iter_hit", int'(max_iter_hit), int'(exp_hit));
    chk_v("a_diag", a_diag, a_hist[exp_iter]);
    chk_v("a_cur_final", a_cur, a_hist[exp_iter]);
    chk_i("eig_enable", int'(eig_enable), 1);
    chk_i("busy_done", int'(busy), 0);
    chk_i("qr_pulses", n_qr, exp_iter);
    chk_i("mult_pulses", n_mul, exp_iter);
    @(posedge clk); #1;
    chk_i("done_held", int'(done), 1);
    chk_i("iter_held", int'(iter_count), exp_iter);
  endtask

  initial begin
    int it, lat, n;
    bit hit;
    logic [255:0] ai;

    vecs[0] = '{dq: 3, dm: 3, conv: 3, exp_iter: 3, exp_hit: 1'b0, exp_lat: 28};
    vecs[1] = '{dq: 1, dm: 1, conv: 0, exp_iter: 4, exp_hit: 1'b1, exp_lat: 21};
    vecs[2] = '{dq: 2, dm: 1, conv: 4, exp_iter: 4, exp_hit: 1'b0, exp_lat: 25};
    vecs[3] = '{dq: 1, dm: 1, conv: 1, exp_iter: 1, exp_hit: 1'b0, exp_lat: 6};
    vecs[4] = '{dq: 5, dm: 2, conv: 2, exp_iter: 2, exp_hit: 1'b0, exp_lat: 21};
    vecs[5] = '{dq: 1, dm: 4, conv: 0, exp_iter: 4, exp_hit: 1'b1, exp_lat: 33};

    rst = 1'b1; start = 1'b0; a_init = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("idle_hold");

    // The first vector also pulses start during QR_WAIT; it must be ignored.
    for (int i = 0; i < 6; i++) begin
      run_check(vecs[i].dq, vecs[i].dm, vecs[i].conv, vecs[i].exp_iter,
                vecs[i].exp_hit, vecs[i].exp_lat, i == 0);
    end

    for (int r = 0; r < 8; r++) begin
      int dq, dm, conv;
      dq   = int'($urandom_range(1, 4));
      dm   = int'($urandom_range(1, 4));
      conv = int'($urandom_range(0, 6));
      model(dq, dm, conv, it, hit, lat);
      run_check(dq, dm, conv, it, hit, lat, r[0]);
    end

    // Reset asserted while waiting on the second R*Q result.
    cfg_dq = 2; cfg_dm = 3; cfg_conv = 0;
    run_id++;
    start = 1'b1; a_init = rnd256();
    @(posedge clk); #1;
    start = 1'b0; n = 0;
    while (n_mul < 2 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk_i("rst_reach_mul2", n_mul, 2);
    chk_i("rst_pre_iter", int'(iter_count), 1);
    chk_i("rst_pre_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle("midrun_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("post_rst");
    model(2, 3, 2, it, hit, lat);
    run_check(2, 3, 2, it, hit, lat, 1'b0);

`ifdef QR_WATCHDOG_EN
    cfg_dq = 1000; cfg_dm = 1; cfg_conv = 1;
    run_id++;
    ai = rnd256();
    start = 1'b1; a_init = ai;
    @(posedge clk); #1;
    start = 1'b0; n = 1;
    while (!done && n < 200) begin
      @(posedge clk); #1; n++;
      if (n == 16) chk_i("wd_not_early", int'(done), 0);
    end
    chk_i("wd_done", int'(done), 1);
    chk_i("wd_timeout_err", int'(timeout_err), 1);
    chk_i("wd_cycle_window", int'(n >= 17 && n <= 18), 1);
    chk_v("wd_a_diag", a_diag, ai);
    chk_i("wd_no_cap", int'(max_iter_hit), 0);
    run_check(1, 1, 1, 1, 1'b0, 6, 1'b0);
    chk_i("wd_cleared", int'(timeout_err), 0);
`else
    ai = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
